// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, reset vector and fetch-mode encoding for the CPU front end.
package cpu_pkg;
  localparam int CPU_XLEN = 32;
  localparam int CPU_IMEM_AW = 14;
  localparam logic [CPU_XLEN-1:0] CPU_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  typedef enum logic {MODE_LOAD = 1'b0, MODE_RUN = 1'b1} mode_e;
endpackage

// File: rtl/ifetch_stage_if.sv
// ifetch_stage_if: decode-side handshake, redirect and upgrade-load signals of the fetch stage.
interface ifetch_stage_if
  import cpu_pkg::*;
#(
  parameter int XLEN = CPU_XLEN,
  parameter int IMEM_AW = CPU_IMEM_AW
);
  logic stall_i;
  logic redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic upg_rst_i;
  logic upg_done_i;
  logic upg_wen_i;
  logic [IMEM_AW-1:0] upg_adr_i;
  logic [31:0] upg_dat_i;
  logic [31:0] inst_o;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] pc4_o;
  logic valid_o;
  logic misalign_o;
  modport master (
    output stall_i, redirect_i, redirect_pc_i, upg_rst_i, upg_done_i, upg_wen_i, upg_adr_i, upg_dat_i,
    input inst_o, pc_o, pc4_o, valid_o, misalign_o
  );
  modport slave (
    input stall_i, redirect_i, redirect_pc_i, upg_rst_i, upg_done_i, upg_wen_i, upg_adr_i, upg_dat_i,
    output inst_o, pc_o, pc4_o, valid_o, misalign_o
  );
endinterface

// File: rtl/imem_bram.sv
// imem_bram: single-port synchronous instruction RAM, 1-cycle read, read-first, output holds when idle.
module imem_bram
  import cpu_pkg::*;
#(
  parameter int IMEM_AW = CPU_IMEM_AW
) (
  input  logic               clk,
  input  logic               en,
  input  logic               we,
  input  logic [IMEM_AW-1:0] addr,
  input  logic [31:0]        din,
  output logic [31:0]        dout
);
  logic [31:0] mem [2**IMEM_AW];
  always_ff @(posedge clk) begin
    if (en) begin
      dout <= mem[addr];
      if (we) mem[addr] <= din;
    end
  end
endmodule

// File: rtl/ifetch_stage.sv
// ifetch_stage: PC register plus instruction memory, presenting valid-qualified inst/pc pairs to decode.
module ifetch_stage
  import cpu_pkg::*;
#(
  parameter int XLEN = CPU_XLEN,
  parameter int IMEM_AW = CPU_IMEM_AW,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(CPU_RESET_PC)
) (
  input logic clk,
  input logic rst,
  ifetch_stage_if.slave bus
);
  mode_e mode;
  logic load;
  logic mem_en;
  logic mem_we;
  logic [IMEM_AW-1:0] mem_addr;
  logic [XLEN-1:0] fetch_pc;
  assign mode = (bus.upg_rst_i | bus.upg_done_i) ? MODE_RUN : MODE_LOAD;
  assign load = (mode == MODE_LOAD);
  // Idle the RAM on stall or trap so its output register keeps the shown instruction.
  assign mem_en = load | ~(bus.misalign_o | (bus.stall_i & ~bus.redirect_i));
  assign mem_we = load & bus.upg_wen_i & ~rst;
  assign mem_addr = load ? bus.upg_adr_i : fetch_pc[IMEM_AW+1:2];
  imem_bram #(.IMEM_AW(IMEM_AW)) u_imem (
    .clk(clk),
    .en(mem_en),
    .we(mem_we),
    .addr(mem_addr),
    .din(bus.upg_dat_i),
    .dout(bus.inst_o)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      bus.pc_o <= RESET_PC;
      bus.pc4_o <= RESET_PC + XLEN'(4);
      bus.valid_o <= 1'b0;
      bus.misalign_o <= 1'b0;
    end else if (load) begin
      fetch_pc <= RESET_PC;
      bus.valid_o <= 1'b0;
    end else if (bus.misalign_o) begin
      bus.valid_o <= 1'b0;
    end else if (bus.redirect_i) begin
      // The read already in flight is discarded, leaving one bubble.
      bus.valid_o <= 1'b0;
      if (bus.redirect_pc_i[1:0] != 2'b00) bus.misalign_o <= 1'b1;
      else fetch_pc <= bus.redirect_pc_i;
    end else if (!bus.stall_i) begin
      bus.pc_o <= fetch_pc;
      bus.pc4_o <= fetch_pc + XLEN'(4);
      bus.valid_o <= 1'b1;
      fetch_pc <= fetch_pc + XLEN'(4);
    end
  end
endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage: directed checks of fetch sequencing, stall, redirect, trap, wrap and reload.
module tb_ifetch_stage;
  import cpu_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int failed = 0;
  always #5 clk = ~clk;
  ifetch_stage_if #(.XLEN(32), .IMEM_AW(4)) bus ();
  ifetch_stage #(.XLEN(32), .IMEM_AW(4), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  function automatic logic [31:0] v(int i);
    return 32'h11 * (i + 1);
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic show(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    chk({tag, " valid"}, 32'(bus.valid_o), 32'd1);
    chk({tag, " pc"}, bus.pc_o, pc);
    chk({tag, " pc4"}, bus.pc4_o, pc + 32'd4);
    chk({tag, " inst"}, bus.inst_o, inst);
  endtask
  initial begin
    rst = 1'b1;
    bus.stall_i = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = '0;
    bus.upg_rst_i = 1'b0;
    bus.upg_done_i = 1'b0;
    bus.upg_wen_i = 1'b0;
    bus.upg_adr_i = '0;
    bus.upg_dat_i = '0;
    step();
    step();
    chk("rst pc", bus.pc_o, 32'h0);
    chk("rst pc4", bus.pc4_o, 32'h4);
    chk("rst valid", 32'(bus.valid_o), 32'd0);
    chk("rst misalign", 32'(bus.misalign_o), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.upg_wen_i = 1'b1;
      bus.upg_adr_i = 4'(i);
      bus.upg_dat_i = v(i);
      step();
      chk("load valid", 32'(bus.valid_o), 32'd0);
    end
    bus.upg_wen_i = 1'b0;
    bus.upg_done_i = 1'b1;
    step();
    show("seq0", 32'h0, 32'h11);
    step();
    show("seq1", 32'h4, 32'h22);
    step();
    show("seq2", 32'h8, 32'h33);
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      show("stall", 32'h8, 32'h33);
    end
    bus.stall_i = 1'b0;
    step();
    show("release", 32'hC, 32'h44);
    bus.stall_i = 1'b1;
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h20;
    step();
    chk("redir bubble", 32'(bus.valid_o), 32'd0);
    bus.stall_i = 1'b0;
    bus.redirect_i = 1'b0;
    step();
    show("redir tgt", 32'h20, v(8));
    step();
    show("redir next", 32'h24, v(9));
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h10;
    step();
    chk("b2b bubble1", 32'(bus.valid_o), 32'd0);
    bus.redirect_pc_i = 32'h30;
    step();
    chk("b2b bubble2", 32'(bus.valid_o), 32'd0);
    bus.redirect_i = 1'b0;
    step();
    show("b2b tgt", 32'h30, v(12));
    step();
    step();
    step();
    show("pre wrap", 32'h3C, v(15));
    step();
    show("wrap", 32'h40, v(0));
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h42;
    step();
    chk("mis set", 32'(bus.misalign_o), 32'd1);
    chk("mis valid", 32'(bus.valid_o), 32'd0);
    bus.redirect_pc_i = 32'h0;
    step();
    bus.redirect_i = 1'b0;
    step();
    step();
    chk("mis sticky", 32'(bus.misalign_o), 32'd1);
    chk("mis frozen valid", 32'(bus.valid_o), 32'd0);
    chk("mis frozen pc", bus.pc_o, 32'h40);
    rst = 1'b1;
    step();
    chk("rst2 misalign", 32'(bus.misalign_o), 32'd0);
    chk("rst2 valid", 32'(bus.valid_o), 32'd0);
    chk("rst2 pc", bus.pc_o, 32'h0);
    rst = 1'b0;
    step();
    show("restart", 32'h0, 32'h11);
    bus.stall_i = 1'b1;
    step();
    rst = 1'b1;
    step();
    chk("rst stall valid", 32'(bus.valid_o), 32'd0);
    rst = 1'b0;
    bus.stall_i = 1'b0;
    step();
    show("post rst", 32'h0, 32'h11);
    step();
    show("post rst1", 32'h4, 32'h22);
    bus.upg_done_i = 1'b0;
    bus.upg_wen_i = 1'b1;
    bus.upg_adr_i = 4'd0;
    bus.upg_dat_i = 32'hAA;
    bus.stall_i = 1'b1;
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h8;
    step();
    chk("upg valid", 32'(bus.valid_o), 32'd0);
    bus.upg_wen_i = 1'b0;
    bus.stall_i = 1'b0;
    bus.redirect_i = 1'b0;
    step();
    chk("upg valid2", 32'(bus.valid_o), 32'd0);
    bus.upg_rst_i = 1'b1;
    step();
    show("upg run", 32'h0, 32'hAA);
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h1000_0004;
    step();
    bus.redirect_i = 1'b0;
    step();
    show("hi bits", 32'h1000_0004, v(1));
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFFC;
    step();
    bus.redirect_i = 1'b0;
    step();
    show("top pc", 32'hFFFF_FFFC, v(15));
    step();
    show("pc wrap", 32'h0, 32'hAA);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
